// File: rtl/sm_hex_display.sv
// Multiplexed hex display of a 32-bit word with per-scan snapshot and digit gap.
// Define SM_HEX_LZB_EN to blank leading zero digits.
module sm_hex_display #(
  parameter int DIGITS     = 8,
  parameter int PRESCALE_W = 16,
  parameter int GAP        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [31:0]       data,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        seg,
  output logic              scan_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

  typedef enum logic {DRIVE, BLANK} state_e;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [31:0]           snap_q, snap_d;
  logic [DIGITS-1:0]     anode_d;
  logic [6:0]            seg_d;
  logic                  done_d;
  logic                  adv;
  logic                  show;
  logic [3:0]            nib;
`ifdef SM_HEX_LZB_EN
  logic [2:0]            lead_q, lead_d;
`endif

  function automatic logic [6:0] font(input logic [3:0] n);
    unique case (n)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

`ifdef SM_HEX_LZB_EN
  function automatic logic [2:0] lead_of(input logic [31:0] w);
    lead_of = '0;
    for (int i = 0; i < 8; i++)
      if (w[4*i +: 4] != 4'h0) lead_of = 3'(i);
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      pre_q     <= '0;
      gap_q     <= '0;
      idx_q     <= LAST;
      snap_q    <= '0;
      anode     <= '1;
      seg       <= 7'h7F;
      scan_done <= 1'b0;
`ifdef SM_HEX_LZB_EN
      lead_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      anode     <= anode_d;
      seg       <= seg_d;
      scan_done <= done_d;
`ifdef SM_HEX_LZB_EN
      lead_q    <= lead_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    adv     = 1'b0;
`ifdef SM_HEX_LZB_EN
    lead_d  = lead_q;
`endif
    if (en) begin
      unique case (state_q)
        DRIVE: begin
          if (&pre_q) begin
            pre_d = '0;
            if (GAP == 0) adv = 1'b1;
            else state_d = BLANK;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: begin
          if (GAP == 0 || gap_q == GLAST) begin
            gap_d = '0;
            adv   = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      endcase
    end
    // Snapshot only on wrap to digit 0 so a scan never tears.
    if (adv) begin
      state_d = DRIVE;
      if (idx_q == LAST) begin
        idx_d  = '0;
        snap_d = data;
`ifdef SM_HEX_LZB_EN
        lead_d = lead_of(data);
`endif
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    nib  = snap_q[{idx_q, 2'b00} +: 4];
    show = en && (state_q == DRIVE);
`ifdef SM_HEX_LZB_EN
    show = show && (3'(idx_q) <= lead_q);
`endif
    anode_d = show ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d   = show ? font(nib) : 7'h7F;
    done_d  = en && (state_q == DRIVE) && (&pre_q)
              && (idx_q == LAST);
  end

endmodule

// File: tb/tb_sm_hex_display.sv
// Scoreboard bench for sm_hex_display with a cycle-level reference model.
// Build with SM_HEX_LZB_EN to also cover leading-zero blanking.
module tb_sm_hex_display;

  localparam int DIGITS = 8;
  localparam int PW     = 2;
  localparam int GAP    = 1;
  localparam int DRV    = 1 << PW;
  localparam int PER    = DRV + GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  anode;
  logic [6:0]  seg;
  logic        scan_done;

  sm_hex_display #(
    .DIGITS(DIGITS), .PRESCALE_W(PW), .GAP(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data),
    .anode(anode), .seg(seg), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] sg;
    logic       dn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done = -1;
  int m_idx, m_ph, m_lead;
  logic [31:0] m_snap;
  logic        nxt_en = 1'b1;
  logic [31:0] nxt_data = '0;
  logic [6:0]  FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lead_of(input logic [31:0] w);
    int l = 0;
    for (int i = 0; i < 8; i++)
      if (((w >> (4*i)) & 32'hF) != 0) l = i;
    return l;
  endfunction

  task automatic m_reset();
    m_idx = DIGITS - 1;
    m_ph = DRV;
    m_snap = '0;
    m_lead = 0;
    q.delete();
    last_done = -1;
  endtask

  task automatic drive_predict();
    exp_t e;
    logic show;
    logic [3:0] n;
    en = nxt_en;
    data = nxt_data;
    show = nxt_en && (m_ph < DRV);
`ifdef SM_HEX_LZB_EN
    show = show && (m_idx <= m_lead);
`endif
    n = 4'((m_snap >> (4*m_idx)) & 32'hF);
    e.an = show ? ~(8'(1) << m_idx) : 8'hFF;
    e.sg = show ? FONT[n] : 7'h7F;
    e.dn = nxt_en && (m_ph == DRV-1) && (m_idx == DIGITS-1);
    q.push_back(e);
    if (nxt_en) begin
      if (m_ph == PER-1) begin
        m_ph = 0;
        m_idx = (m_idx == DIGITS-1) ? 0 : m_idx + 1;
        if (m_idx == 0) begin
          m_snap = nxt_data;
          m_lead = lead_of(nxt_data);
        end
      end else begin
        m_ph++;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("anode", 32'(anode), 32'(e.an));
      chk("seg", 32'(seg), 32'(e.sg));
      chk("scan_done", 32'(scan_done), 32'(e.dn));
    end
    if (scan_done === 1'b1) begin
      if (last_done >= 0)
        chk("scan_period", cyc - last_done, DIGITS*PER);
      last_done = cyc;
    end
    drive_predict();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_an(input logic [7:0] a, input string tag);
    int k = 0;
    while (anode !== a && k < 100) begin
      tick();
      k++;
    end
    if (anode !== a) chk({tag, "_timeout"}, 32'(anode), 32'(a));
  endtask

  task automatic reset_hold(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("rst_anode", 32'(anode), 32'hFF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_done", 32'(scan_done), 32'h0);
    end
    rst_n = 1'b1;
    drive_predict();
  endtask

  int dark_bad;

  initial begin
    m_reset();
    reset_hold(3);
    ticks(90);
    wait_an(8'hFE, "t1_d0");
    chk("t1_seg0", 32'(seg), 32'h40);

    nxt_data = 32'h89ABCDEF;
    ticks(45);
    wait_an(8'hFE, "t2_d0");
    chk("t2_seg0", 32'(seg), 32'h0E);
    wait_an(8'hFD, "t2_d1");
    chk("t2_seg1", 32'(seg), 32'h06);
    wait_an(8'hFB, "t2_d2");
    chk("t2_seg2", 32'(seg), 32'h21);
    wait_an(8'h7F, "t2_d7");
    chk("t2_seg7", 32'(seg), 32'h00);

    nxt_data = 32'h11111111;
    ticks(45);
    wait_an(8'hF7, "t3_d3");
    nxt_data = 32'h22222222;
    wait_an(8'hEF, "t3_d4");
    chk("t3_seg4", 32'(seg), 32'h79);
    wait_an(8'h7F, "t3_d7");
    chk("t3_seg7", 32'(seg), 32'h79);
    wait_an(8'hFE, "t3_next");
    chk("t3_next_seg", 32'(seg), 32'h24);

    wait_an(8'hDF, "t4_d5");
    tick();
    nxt_en = 1'b0;
    last_done = -1;
    ticks(10);
    nxt_en = 1'b1;
    ticks(60);

    nxt_data = 32'h12345678;
    wait_an(8'hEF, "t5_d4");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_anode", 32'(anode), 32'hFF);
    chk("async_seg", 32'(seg), 32'h7F);
    m_reset();
    reset_hold(3);
    wait_an(8'hFE, "t5_d0");
    chk("t5_seg0", 32'(seg), 32'h00);
    ticks(50);

`ifdef SM_HEX_LZB_EN
    nxt_data = 32'h000000A5;
    ticks(45);
    wait_an(8'hFE, "t6_d0");
    chk("t6_seg0", 32'(seg), 32'h12);
    wait_an(8'hFD, "t6_d1");
    chk("t6_seg1", 32'(seg), 32'h08);
    dark_bad = 0;
    repeat (40) begin
      tick();
      if (anode !== 8'hFE && anode !== 8'hFD && anode !== 8'hFF)
        dark_bad++;
    end
    chk("t6_dark", dark_bad, 0);
    nxt_data = 32'h0;
    ticks(45);
    dark_bad = 0;
    repeat (40) begin
      tick();
      if (anode !== 8'hFE && anode !== 8'hFF) dark_bad++;
      if (anode === 8'hFE && seg !== 7'h40) dark_bad++;
    end
    chk("t6_zero", dark_bad, 0);
`else
    dark_bad = 0;
    repeat (40) begin
      tick();
      if (anode === 8'h7F) dark_bad++;
    end
    chk("all_digits_lit", 32'(dark_bad > 0), 32'h1);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
